// File: rtl/i2s_frame_buffer.sv
// -----------------------------------------------------------------------------
// i2s_frame_buffer
//
// Collects audio samples from an I2S receiver into frames of FRAME_LEN words
// using two ping-pong banks. While one bank fills, the other bank holds the
// last complete frame for a consumer, which reads it by index. The consumer
// acknowledges the frame with frame_ack_i when it is finished with it. A frame
// that completes while the previous one is still held (and not acknowledged
// in that cycle) is discarded, and overflow_o pulses.
//
// Optional feature macro: I2S_FRAME_BUF_MONO_MIX_EN
//   undefined : the stored sample is the left channel unchanged
//   defined   : the stored sample is the average (L + R) >>> 1
//
// Ports
//   clk                 : system clock, rising edge
//   rst                 : asynchronous active-high reset
//   i2s_sample_data_L_i : left sample (bclk domain)
//   i2s_sample_data_R_i : right sample (bclk domain)
//   i2s_done_i          : high while both samples are complete (bclk domain)
//   frame_ready_o       : a complete frame is held for the consumer
//   frame_ack_i         : one-cycle pulse releasing the held frame
//   rd_addr_i           : read index into the held frame
//   rd_data_o           : registered sample at rd_addr_i (1-cycle latency)
//   overflow_o          : one-cycle pulse when a completed frame is discarded
// -----------------------------------------------------------------------------
module i2s_frame_buffer #(
  parameter int DATA_BITS = 16,
  parameter int FRAME_LEN = 256,
  localparam int ADDR_BITS = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] i2s_sample_data_L_i,
  input  logic [DATA_BITS-1:0] i2s_sample_data_R_i,
  input  logic                 i2s_done_i,
  output logic                 frame_ready_o,
  input  logic                 frame_ack_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 overflow_o
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // done synchroniser and rising-edge detection
  // ---------------------------------------------------------------------------
  logic done_s1_q, done_s2_q, done_s3_q;
  logic vld1_q, vld2_q;
  logic armed_q;
  logic strobe;

  // vld1_q/vld2_q mark that done_s1_q/done_s2_q hold a real sample of the
  // input rather than their reset value. The detector only arms once a real
  // low level has been seen, so a done that is already high when reset is
  // released never produces a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_s1_q <= 1'b0;
      done_s2_q <= 1'b0;
      done_s3_q <= 1'b0;
      vld1_q    <= 1'b0;
      vld2_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      done_s1_q <= i2s_done_i;
      done_s2_q <= done_s1_q;
      done_s3_q <= done_s2_q;
      vld1_q    <= 1'b1;
      vld2_q    <= vld1_q;
      armed_q   <= armed_q | (vld2_q & ~done_s2_q);
    end
  end

  assign strobe = done_s2_q & ~done_s3_q & armed_q;

  // ---------------------------------------------------------------------------
  // sample capture (bclk-domain data is stable long after done rises)
  // ---------------------------------------------------------------------------
  logic                 cap_vld_q;
  logic [DATA_BITS-1:0] cap_l_q;
  logic [DATA_BITS-1:0] wr_sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_vld_q <= 1'b0;
      cap_l_q   <= '0;
    end else begin
      cap_vld_q <= strobe;
      if (strobe) begin
        cap_l_q <= i2s_sample_data_L_i;
      end
    end
  end

`ifdef I2S_FRAME_BUF_MONO_MIX_EN
  logic [DATA_BITS-1:0] cap_r_q;
  logic signed [DATA_BITS:0] mix_sum;
  logic unused_mix_lsb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_r_q <= '0;
    end else if (strobe) begin
      cap_r_q <= i2s_sample_data_R_i;
    end
  end

  // One extra bit holds the full sum; dropping the LSB is the arithmetic
  // shift, so the average always fits back into DATA_BITS.
  assign mix_sum        = $signed({cap_l_q[DATA_BITS-1], cap_l_q})
                        + $signed({cap_r_q[DATA_BITS-1], cap_r_q});
  assign wr_sample      = mix_sum[DATA_BITS:1];
  assign unused_mix_lsb = mix_sum[0];
`else
  logic unused_r;

  assign wr_sample = cap_l_q;
  assign unused_r  = ^i2s_sample_data_R_i;
`endif

  // ---------------------------------------------------------------------------
  // write index, bank select and reader FSM
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic                 bank_q, bank_d;     // bank currently being written
  logic [ADDR_BITS-1:0] wr_idx_q, wr_idx_d;
  logic                 ovf_q, ovf_d;
  logic                 frame_done;

  assign frame_done = cap_vld_q && (wr_idx_q == ADDR_BITS'(FRAME_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      bank_q   <= 1'b0;
      wr_idx_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      wr_idx_q <= wr_idx_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    wr_idx_d = wr_idx_q;
    ovf_d    = 1'b0;

    // FRAME_LEN is a power of two, so the index wraps to 0 by itself
    // after the last word of a frame, whether the frame is kept or dropped.
    if (cap_vld_q) begin
      wr_idx_d = wr_idx_q + ADDR_BITS'(1);
    end

    case (state_q)
      ST_EMPTY: begin
        if (frame_done) begin
          bank_d  = ~bank_q;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (frame_done) begin
          // An ack in the same cycle frees the read bank just in time.
          if (frame_ack_i) begin
            bank_d = ~bank_q;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (frame_ack_i) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign frame_ready_o = (state_q == ST_HELD);
  assign overflow_o    = ovf_q;

  // ---------------------------------------------------------------------------
  // ping-pong storage: {bank, index} addressing, writes only to bank_q
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [2*FRAME_LEN];
  logic [DATA_BITS-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (cap_vld_q) begin
      mem_q[{bank_q, wr_idx_q}] <= wr_sample;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[{~bank_q, rd_addr_i}];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_i2s_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_i2s_frame_buffer
//
// Directed bench for i2s_frame_buffer with FRAME_LEN=4, DATA_BITS=16.
// A frame-level model (queue of pending samples, held frame array) predicts
// frame_ready_o, overflow_o and rd_data_o every cycle; literal expectations
// pin the model on the key scenarios.
// -----------------------------------------------------------------------------
module tb_i2s_frame_buffer;

  localparam int DB = 16;
  localparam int FL = 4;

  logic          clk;
  logic          rst;
  logic [DB-1:0] sample_l, sample_r;
  logic          done;
  logic          frame_ready;
  logic          ack;
  logic [1:0]    rd_addr;
  logic [DB-1:0] rd_data;
  logic          overflow;

  i2s_frame_buffer #(.DATA_BITS(DB), .FRAME_LEN(FL)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i2s_sample_data_L_i (sample_l),
    .i2s_sample_data_R_i (sample_r),
    .i2s_done_i          (done),
    .frame_ready_o       (frame_ready),
    .frame_ack_i         (ack),
    .rd_addr_i           (rd_addr),
    .rd_data_o           (rd_data),
    .overflow_o          (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // frame-level model
  // ---------------------------------------------------------------------------
  typedef struct {
    int          edge_n;
    logic [15:0] val;
  } wr_t;

  wr_t         sched[$];
  logic [15:0] fill_q[$];
  logic [15:0] held_frame [FL];
  logic        held;
  logic        prev_done;
  logic        exp_ovf;
  logic        exp_rd_valid;
  logic [15:0] exp_rd;
  int          edge_cnt;

  function automatic logic [15:0] stored_value(input logic [15:0] l, input logic [15:0] r);
`ifdef I2S_FRAME_BUF_MONO_MIX_EN
    int s;
    s = int'($signed(l)) + int'($signed(r));
    return 16'(s >>> 1);
`else
    logic [15:0] unused_r;
    unused_r = r;
    return l;
`endif
  endfunction

  // A rising done seen at an edge lands in memory three edges later.
  initial begin
    wr_t w;
    held         = 1'b0;
    prev_done    = 1'b1;
    exp_ovf      = 1'b0;
    exp_rd_valid = 1'b0;
    exp_rd       = '0;
    edge_cnt     = 0;
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (rst) begin
        held         = 1'b0;
        fill_q.delete();
        sched.delete();
        prev_done    = 1'b1;
        exp_ovf      = 1'b0;
        exp_rd_valid = 1'b0;
      end else begin
        exp_rd_valid = held;
        exp_rd       = held_frame[rd_addr];
        exp_ovf      = 1'b0;
        if (sched.size() > 0 && sched[0].edge_n == edge_cnt) begin
          fill_q.push_back(sched[0].val);
          void'(sched.pop_front());
          if (fill_q.size() == FL) begin
            if (!held || ack) begin
              for (int i = 0; i < FL; i++) held_frame[i] = fill_q[i];
              held = 1'b1;
            end else begin
              exp_ovf = 1'b1;
            end
            fill_q.delete();
          end else if (held && ack) begin
            held = 1'b0;
          end
        end else if (held && ack) begin
          held = 1'b0;
        end
        if (done && !prev_done) begin
          w.edge_n = edge_cnt + 3;
          w.val    = stored_value(sample_l, sample_r);
          sched.push_back(w);
        end
        prev_done = done;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // compare process (sole owner of the counters)
  // ---------------------------------------------------------------------------
  int          vec_cnt;
  int          err_cnt;
  int          ovf_seen;
  logic        lit_en;
  int          lit_kind;     // 0: rd_data, 1: overflow pulse count, 2: frame_ready
  logic [15:0] lit_exp;
  string       lit_name;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    vec_cnt  = 0;
    err_cnt  = 0;
    ovf_seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_ready", {15'd0, frame_ready}, 16'd0);
        check("rst_ovf", {15'd0, overflow}, 16'd0);
        check("rst_rd_data", rd_data, 16'd0);
      end else begin
        if (overflow === 1'b1) ovf_seen++;
        check("frame_ready", {15'd0, frame_ready}, {15'd0, held});
        check("overflow", {15'd0, overflow}, {15'd0, exp_ovf});
        if (exp_rd_valid) check("rd_data", rd_data, exp_rd);
      end
      if (lit_en) begin
        case (lit_kind)
          0:       check(lit_name, rd_data, lit_exp);
          1:       check(lit_name, 16'(ovf_seen), lit_exp);
          default: check(lit_name, {15'd0, frame_ready}, lit_exp);
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [15:0] l, input logic [15:0] r, input logic ack_on_write);
    sample_l = l;
    sample_r = r;
    done     = 1'b1;
    repeat (3) tick();
    if (ack_on_write) ack = 1'b1;   // sampled on the edge that writes this sample
    tick();
    ack = 1'b0;
    repeat (2) tick();
    done = 1'b0;
    repeat (6) tick();
  endtask

  task automatic expect_lit(input int kind, input logic [15:0] exp, input string name);
    lit_kind = kind;
    lit_exp  = exp;
    lit_name = name;
    lit_en   = 1'b1;
    tick();
    lit_en   = 1'b0;
  endtask

  task automatic read_lit(input logic [1:0] a, input logic [15:0] exp);
    rd_addr = a;
    tick();
    expect_lit(0, exp, $sformatf("read_addr%0d", a));
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    done     = 1'b0;
    ack      = 1'b0;
    sample_l = '0;
    sample_r = '0;
    rd_addr  = '0;
    lit_en   = 1'b0;
    lit_kind = 0;
    lit_exp  = '0;
    lit_name = "";
    repeat (4) tick();
    rst = 1'b0;
    repeat (3) tick();

    // first frame 1..4
    for (int i = 1; i <= 4; i++) pulse(16'(i), 16'(i), 1'b0);
    expect_lit(2, 16'd1, "ready_frame1");
    for (int i = 0; i < 4; i++) read_lit(2'(i), 16'(i + 1));

    // second frame without ack: discarded
    for (int i = 5; i <= 8; i++) pulse(16'(i), 16'(i), 1'b0);
    expect_lit(1, 16'd1, "ovf_count_after_drop");
    for (int i = 0; i < 4; i++) read_lit(2'(i), 16'(i + 1));

    // ack coincident with the completing write
    for (int i = 9; i <= 11; i++) pulse(16'(i), 16'(i), 1'b0);
    pulse(16'd12, 16'd12, 1'b1);
    expect_lit(2, 16'd1, "ready_after_ack_swap");
    expect_lit(1, 16'd1, "ovf_count_after_ack_swap");
    for (int i = 0; i < 4; i++) read_lit(2'(i), 16'(i + 9));

    // release, then ack while empty
    ack_pulse();
    expect_lit(2, 16'd0, "ready_after_ack");
    ack_pulse();
    expect_lit(2, 16'd0, "ready_ack_in_empty");

    // reset mid-frame
    pulse(16'd20, 16'd20, 1'b0);
    pulse(16'd21, 16'd21, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    expect_lit(2, 16'd0, "ready_in_reset");
    rst = 1'b0;
    repeat (3) tick();
    for (int i = 31; i <= 34; i++) pulse(16'(i), 16'(i), 1'b0);
    expect_lit(2, 16'd1, "ready_post_reset_frame");
    for (int i = 0; i < 4; i++) read_lit(2'(i), 16'(i + 31));
    ack_pulse();

    // done held high across reset release
    sample_l = 16'd99;
    sample_r = 16'd99;
    done     = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (8) tick();
    done = 1'b0;
    repeat (6) tick();
    for (int i = 41; i <= 43; i++) pulse(16'(i), 16'(i), 1'b0);
    expect_lit(2, 16'd0, "ready_after_3_post_release");
    pulse(16'd44, 16'd44, 1'b0);
    expect_lit(2, 16'd1, "ready_after_4_post_release");
    for (int i = 0; i < 4; i++) read_lit(2'(i), 16'(i + 41));
    ack_pulse();

    // stored-sample rule with distinct L and R
    pulse(16'h7FFF, 16'h7FFF, 1'b0);
    pulse(16'h8000, 16'h8000, 1'b0);
    pulse(16'h0001, 16'hFFFE, 1'b0);
    pulse(16'h0005, 16'h0003, 1'b0);
`ifdef I2S_FRAME_BUF_MONO_MIX_EN
    read_lit(2'd0, 16'h7FFF);
    read_lit(2'd1, 16'h8000);
    read_lit(2'd2, 16'hFFFF);
    read_lit(2'd3, 16'h0004);
`else
    read_lit(2'd0, 16'h7FFF);
    read_lit(2'd1, 16'h8000);
    read_lit(2'd2, 16'h0001);
    read_lit(2'd3, 16'h0005);
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/i2s_frame_buffer.md
I2S_FRAME_BUFFER -- requirements
Module: i2s_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 16, width of one audio sample.
REQ-002 SHALL have parameter FRAME_LEN, default 256, samples per frame; power of two, minimum 4.
REQ-003 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i2s_sample_data_L_i  input  DATA_BITS  left sample from the I2S receiver, bclk domain, two's complement.
REQ-006 SHALL have port i2s_sample_data_R_i  input  DATA_BITS  right sample from the I2S receiver, bclk domain, two's complement.
REQ-007 SHALL have port i2s_done_i  input  1  high while both L and R samples are complete, bclk domain.
REQ-008 SHALL have port frame_ready_o  output  1  a complete frame is held for the consumer.
REQ-009 SHALL have port frame_ack_i  input  1  one-cycle pulse from the consumer releasing the held frame.
REQ-010 SHALL have port rd_addr_i  input  log2(FRAME_LEN)  read index into the held frame.
REQ-011 SHALL have port rd_data_o  output  DATA_BITS  sample at rd_addr_i in the held frame.
REQ-012 SHALL have port overflow_o  output  1  one-cycle pulse when a completed frame is discarded.

Function
REQ-013 SHALL synchronise i2s_done_i through two flops and detect its rising edge (capture strobe); clk SHALL be at least 4x bclk.
REQ-014 SHALL register L and R on the cycle after the capture strobe; the inputs are stable for at least one bclk period after done rises.
REQ-015 SHALL write the stored sample (REQ-032) into the write bank at write index, then increment the index; total latency from strobe to memory write is 2 clk cycles.
REQ-016 SHALL hold two banks of FRAME_LEN words (ping-pong): one write bank and one read bank.
REQ-017 SHALL run a reader FSM with states EMPTY (frame_ready_o=0) and HELD (frame_ready_o=1).
REQ-018 On a write at index FRAME_LEN-1 in state EMPTY, SHALL swap banks, wrap the write index to 0, and enter HELD.
REQ-019 On a write at index FRAME_LEN-1 in state HELD without frame_ack_i, SHALL keep the banks, wrap the write index to 0 (frame discarded), pulse overflow_o, and stay HELD.
REQ-020 If frame_ack_i and a frame-completing write occur in the same cycle, SHALL swap banks and remain HELD; overflow_o SHALL stay 0.
REQ-021 On frame_ack_i in HELD with no completing write, SHALL enter EMPTY next cycle.
REQ-022 SHALL ignore frame_ack_i in EMPTY.
REQ-023 SHALL register rd_data_o from the read bank at rd_addr_i with 1-cycle latency in both states; contents are valid only while HELD.
REQ-024 SHALL never write the read bank.

Reset
REQ-025 While rst is high, frame_ready_o=0, overflow_o=0, rd_data_o=0.
REQ-026 Reset SHALL clear the synchroniser flops, the capture registers, the write index (to 0) and the bank select (to 0), and SHALL put the reader FSM in EMPTY.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 A reset mid-frame SHALL discard the partial frame; filling restarts at index 0 on the first strobe after release.
REQ-029 A done level that is already high at reset release SHALL NOT generate a strobe.

Configuration
REQ-030 SHALL support macro I2S_FRAME_BUF_MONO_MIX_EN.
REQ-031 Without I2S_FRAME_BUF_MONO_MIX_EN, the stored sample SHALL be the left sample unchanged.
REQ-032 With I2S_FRAME_BUF_MONO_MIX_EN, the stored sample SHALL be (sign-extended L + sign-extended R) computed at DATA_BITS+1 bits, arithmetic-shifted right by 1, with no overflow possible.

Verification (FRAME_LEN=4 bench, DATA_BITS=16)
REQ-033 Four done pulses carrying L=1,2,3,4 -> frame_ready_o rises 2 cycles after the 4th strobe; reads at addresses 0..3 return 1,2,3,4 one cycle after each address.
REQ-034 Eight done pulses with no ack -> one overflow_o pulse at the 8th write; the held frame still reads 1,2,3,4.
REQ-035 frame_ack_i asserted in the same cycle as the 4th write of the second frame -> frame_ready_o stays 1, overflow_o=0, reads return the new frame.
REQ-036 With MONO_MIX_EN: L=R=16'h7FFF gives 16'h7FFF; L=R=16'h8000 gives 16'h8000; L=1, R=-2 gives 16'hFFFF.
REQ-037 rst asserted after the 2nd strobe, then four strobes -> frame_ready_o=0 during reset; the frame then holds only the four post-reset samples.
REQ-038 i2s_done_i held high across reset release -> no write until done falls and rises again.
